// File: rtl/commit_trace_port.sv
// Commit trace producer: shadow GPR file plus a small record FIFO toward the
// commit consumer, with an ebreak-triggered drain and sticky halt.
module commit_trace_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_inst,
  input  logic            wb_rf_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_rf_wdata,
  output logic            cmt_valid,
  input  logic            cmt_ready,
  output logic [XLEN-1:0] cmt_pc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_wen,
  output logic [4:0]      cmt_rd,
  output logic [XLEN-1:0] cmt_wdata,
  input  logic [4:0]      gpr_raddr,
  output logic [XLEN-1:0] gpr_rdata,
  output logic [63:0]     cmt_count,
  output logic            halt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } rec_t;

  state_e          state_q, state_d;
  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  rec_t            last_q, last_d;
  rec_t            head, out_rec;
  logic [XLEN-1:0] gpr_q [32];
  logic [XLEN-1:0] gpr_d [32];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]     cmt_count_q, cmt_count_d;
  logic            full, empty, push, pop;

  always_comb begin
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    head  = mem_q[rd_ptr_q[AW-1:0]];
    // Empty FIFO shows the most recently popped record rather than a stale slot.
    out_rec = empty ? last_q : head;

    wb_ready  = !full && (state_q == RUN);
    cmt_valid = !empty && (state_q != HALT);
    halt      = (state_q == HALT);
    push      = wb_valid && wb_ready;
    pop       = cmt_valid && cmt_ready;

    cmt_pc    = out_rec.pc;
    cmt_inst  = out_rec.inst;
    cmt_wen   = out_rec.wen;
    cmt_rd    = out_rec.rd;
    cmt_wdata = out_rec.wdata;
    cmt_count = cmt_count_q;
    gpr_rdata = (gpr_raddr == 5'd0) ? '0 : gpr_q[gpr_raddr];

    mem_d       = mem_q;
    gpr_d       = gpr_q;
    last_d      = last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cmt_count_d = cmt_count_q;
    state_d     = state_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{pc: wb_pc, inst: wb_inst,
                                  wen: wb_rf_wen && (wb_rd != 5'd0),
                                  rd: wb_rd, wdata: wb_rf_wdata};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (wb_rf_wen && (wb_rd != 5'd0))
        gpr_d[wb_rd] = wb_rf_wdata;
    end
    if (pop) begin
      last_d      = head;
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      cmt_count_d = cmt_count_q + 64'd1;
    end

    case (state_q)
      RUN:     if (push && (wb_inst == EBREAK)) state_d = DRAIN;
      DRAIN:   if (pop && (head.inst == EBREAK)) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      mem_q       <= '{default: '0};
      gpr_q       <= '{default: '0};
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      gpr_q       <= gpr_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmt_count_q <= cmt_count_d;
    end
  end
endmodule
